// File: rtl/ripple_count_sampler.sv
// Brings an asynchronous ripple counter into the clk domain, waits for it to settle,
// and publishes each new value with its modular increment and a wrap flag.
module ripple_count_sampler #(
   parameter int WIDTH         = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] ripple_q,
   output logic [WIDTH-1:0] count_out,
   output logic             count_valid,
   output logic [WIDTH-1:0] delta,
   output logic             wrap,
   output logic             busy
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] STAB_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                prev_q, prev_d;
   logic [CW-1:0]                   stab_cnt_q, stab_cnt_d;
   logic [WIDTH-1:0]                last_pub_q, last_pub_d;
   logic [WIDTH-1:0]                count_out_q, count_out_d;
   logic [WIDTH-1:0]                delta_q, delta_d;
   logic                            count_valid_q, count_valid_d;
   logic                            wrap_q, wrap_d;

   logic [WIDTH-1:0] sync_val;
   logic             stable;

   assign sync_val = sync_q[SYNC_STAGES-1];
   assign stable   = (stab_cnt_q == STAB_LAST) && (sync_val == prev_q);

   // Synchronizer shifts every cycle, independent of enable
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ripple_q};
      prev_d = sync_val;
   end

   always_comb begin
      state_d       = state_q;
      stab_cnt_d    = stab_cnt_q;
      last_pub_d    = last_pub_q;
      count_out_d   = count_out_q;
      delta_d       = delta_q;
      count_valid_d = 1'b0;
      wrap_d        = 1'b0;
      case (state_q)
         IDLE: begin
            stab_cnt_d = '0;
            if (enable) state_d = SETTLE;
         end
         SETTLE: begin
            if (!enable) begin
               state_d    = IDLE;
               stab_cnt_d = '0;
            end else begin
               if (sync_val != prev_q)       stab_cnt_d = '0;
               else if (stab_cnt_q < STAB_MAX) stab_cnt_d = stab_cnt_q + CW'(1);
               // A settled value equal to the last publish is not news
               if (stable && (sync_val != last_pub_q)) begin
                  state_d       = PUBLISH;
                  count_out_d   = sync_val;
                  delta_d       = sync_val - last_pub_q;
                  wrap_d        = (sync_val < last_pub_q);
                  count_valid_d = 1'b1;
                  last_pub_d    = sync_val;
               end
            end
         end
         PUBLISH: begin
            stab_cnt_d = '0;
            state_d    = enable ? SETTLE : IDLE;
         end
         default: begin
            state_d    = IDLE;
            stab_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sync_q        <= '0;
         prev_q        <= '0;
         stab_cnt_q    <= '0;
         last_pub_q    <= '0;
         count_out_q   <= '0;
         delta_q       <= '0;
         count_valid_q <= 1'b0;
         wrap_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync_q        <= sync_d;
         prev_q        <= prev_d;
         stab_cnt_q    <= stab_cnt_d;
         last_pub_q    <= last_pub_d;
         count_out_q   <= count_out_d;
         delta_q       <= delta_d;
         count_valid_q <= count_valid_d;
         wrap_q        <= wrap_d;
      end
   end

   assign count_out   = count_out_q;
   assign delta       = delta_q;
   assign count_valid = count_valid_q;
   assign wrap        = wrap_q;
   assign busy        = (state_q == SETTLE);

endmodule
